// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine producing the HI/LO pair.
// Shift-add multiply and restoring divide on magnitudes, sign fix at the end.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state, stateNext;
  logic [CW-1:0]      cnt, cntNext;
  logic [1:0]         opReg, opNext;
  logic               negRes, negResNext;
  logic               negRem, negRemNext;
  logic [WIDTH-1:0]   opnd, opndNext;
  logic [2*WIDTH-1:0] acc, accNext;
  logic [WIDTH-1:0]   hiNext, loNext;
  logic               doneNext, dzNext;

  logic               signedOp, divOp;
  logic               aNeg, bNeg;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulStep;
  logic [WIDTH:0]     remShift;
  logic [WIDTH-1:0]   remDiff;
  logic [2*WIDTH-1:0] divStep;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quot, rem;

  assign signedOp = ~op[0];
  assign divOp    = op[1];
  assign aNeg     = signedOp & src_a[WIDTH-1];
  assign bNeg     = signedOp & src_b[WIDTH-1];
  assign aMag     = aNeg ? -src_a : src_a;
  assign bMag     = bNeg ? -src_b : src_b;

  // opnd holds the multiplicand or the divisor; acc low half the other operand
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : '0);
  assign mulStep = {mulSum, acc[WIDTH-1:1]};

  assign remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign remDiff  = remShift[WIDTH-1:0] - opnd;
  assign divStep  = (remShift >= {1'b0, opnd})
                  ? {remDiff, acc[WIDTH-2:0], 1'b1}
                  : {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  assign prodFix = negRes ? -acc : acc;
  assign quot    = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem     = negRem ? -acc[2*WIDTH-1:WIDTH]
                          : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != IDLE);

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    opNext     = opReg;
    negResNext = negRes;
    negRemNext = negRem;
    opndNext   = opnd;
    accNext    = acc;
    hiNext     = hi;
    loNext     = lo;
    doneNext   = 1'b0;
    dzNext     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (divOp && (src_b == '0)) begin
            doneNext = 1'b1;
            dzNext   = 1'b1;
          end else begin
            opNext     = op;
            negResNext = aNeg ^ bNeg;
            negRemNext = aNeg;
            opndNext   = divOp ? bMag : aMag;
            accNext    = {{WIDTH{1'b0}}, divOp ? aMag : bMag};
            cntNext    = CW'(WIDTH);
            stateNext  = CALC;
          end
        end
      end
      CALC: begin
        cntNext = cnt - CW'(1);
        accNext = opReg[1] ? divStep : mulStep;
        if (cnt == CW'(1)) stateNext = FIX;
      end
      FIX: begin
        if (opReg[1]) begin
          hiNext = rem;
          loNext = quot;
        end else begin
          hiNext = prodFix[2*WIDTH-1:WIDTH];
          loNext = prodFix[WIDTH-1:0];
        end
        doneNext  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      opReg    <= '0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      opReg    <= opNext;
      negRes   <= negResNext;
      negRem   <= negRemNext;
      opnd     <= opndNext;
      acc      <= accNext;
      hi       <= hiNext;
      lo       <= loNext;
      done     <= doneNext;
      div_zero <= dzNext;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32 and WIDTH=8.
// Random and directed ops checked against a plain-arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start8;
  logic [1:0]  op, op8;
  logic [31:0] srcA, srcB;
  logic [7:0]  srcA8, srcB8;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;
  logic        busy8, done8, divZero8;
  logic [7:0]  hi8, lo8;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(srcA), .src_b(srcB), .busy(busy), .done(done),
    .div_zero(divZero), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8),
    .src_a(srcA8), .src_b(srcB8), .busy(busy8), .done(done8),
    .div_zero(divZero8), .hi(hi8), .lo(lo8)
  );

  function automatic logic [63:0] refModel(
    input int w, input logic [1:0] o,
    input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ua, ub, up, hv, lv;
    longint      sa, sb, sp, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    hv = '0;
    lv = '0;
    case (o)
      2'b00: begin
        sp = sa * sb;
        hv = ($unsigned(sp) >> w) & mask;
        lv = $unsigned(sp) & mask;
      end
      2'b01: begin
        up = ua * ub;
        hv = (up >> w) & mask;
        lv = up & mask;
      end
      2'b10: begin
        q  = sa / sb;
        r  = sa % sb;
        hv = $unsigned(r) & mask;
        lv = $unsigned(q) & mask;
      end
      default: begin
        hv = (ua % ub) & mask;
        lv = (ua / ub) & mask;
      end
    endcase
    return {hv[31:0], lv[31:0]};
  endfunction

  task automatic doOp(input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, output int lat,
                      output logic bsy0, output logic both);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = $urandom;
    srcA  = $urandom;
    srcB  = $urandom;
    bsy0  = busy;
    both  = 1'b0;
    lat   = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy && done) both = 1'b1;
      if (done) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic doOp8(input logic [1:0] o, input logic [7:0] a,
                       input logic [7:0] b, output int lat);
    @(negedge clk);
    start8 = 1'b1;
    op8    = o;
    srcA8  = a;
    srcB8  = b;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    lat    = 0;
    for (int i = 0; i < 30; i++) begin
      if (done8) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    nChecks++;
    if ({busy, done, divZero} !== 3'b000) begin
      nFails++;
      $display("FAIL reset_flags got %b want 000",
               {busy, done, divZero});
    end
    nChecks++;
    if ({hi, lo} !== 64'd0) begin
      nFails++;
      $display("FAIL reset_hilo got %h want 0", {hi, lo});
    end
    nChecks++;
    if ({busy8, done8, divZero8, hi8, lo8} !== 19'd0) begin
      nFails++;
      $display("FAIL reset_w8 got %h want 0",
               {busy8, done8, divZero8, hi8, lo8});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int lat;
    logic b0, both;
    doOp(2'b00, 32'hFFFF_FFFD, 32'd7, lat, b0, both);
    nChecks++;
    if (lat !== 33) begin
      nFails++;
      $display("FAIL mult_latency got %0d want 33", lat);
    end
    nChecks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      nFails++;
      $display("FAIL mult_neg got %h want FFFFFFFFFFFFFFEB", {hi, lo});
    end
    nChecks++;
    if (b0 !== 1'b1 || both !== 1'b0 || divZero !== 1'b0) begin
      nFails++;
      $display("FAIL mult_flags got busy0=%b both=%b dz=%b want 1 0 0",
               b0, both, divZero);
    end
    @(posedge clk);
    #1;
    nChecks++;
    if (done !== 1'b0) begin
      nFails++;
      $display("FAIL done_pulse got %b want 0", done);
    end
    doOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b0, both);
    nChecks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      nFails++;
      $display("FAIL multu_max got %h want FFFFFFFE00000001", {hi, lo});
    end
  endtask

  task automatic test_div();
    int lat;
    logic b0, both;
    doOp(2'b10, 32'hFFFF_FFF9, 32'd2, lat, b0, both);
    nChecks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD || lat !== 33) begin
      nFails++;
      $display("FAIL div_neg got %h lat %0d want FFFFFFFFFFFFFFFD lat 33",
               {hi, lo}, lat);
    end
    doOp(2'b11, 32'd7, 32'd2, lat, b0, both);
    nChecks++;
    if ({hi, lo} !== 64'h0000_0001_0000_0003) begin
      nFails++;
      $display("FAIL divu got %h want 0000000100000003", {hi, lo});
    end
    doOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, b0, both);
    nChecks++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000 || divZero !== 1'b0) begin
      nFails++;
      $display("FAIL div_ovf got %h dz %b want 0000000080000000 dz 0",
               {hi, lo}, divZero);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic b0, both;
    doOp(2'b11, 32'd7, 32'd2, lat, b0, both);
    doOp(2'b10, 32'd5, 32'd0, lat, b0, both);
    nChecks++;
    if (lat !== 0 || divZero !== 1'b1 || b0 !== 1'b0) begin
      nFails++;
      $display("FAIL divzero_flags got lat=%0d dz=%b busy=%b want 0 1 0",
               lat, divZero, b0);
    end
    nChecks++;
    if ({hi, lo} !== 64'h0000_0001_0000_0003) begin
      nFails++;
      $display("FAIL divzero_hold got %h want 0000000100000003", {hi, lo});
    end
    @(posedge clk);
    #1;
    nChecks++;
    if ({done, divZero, busy} !== 3'b000) begin
      nFails++;
      $display("FAIL divzero_after got %b want 000",
               {done, divZero, busy});
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [63:0] exp;
    exp = refModel(32, 2'b01, 32'd1234, 32'd5678);
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    srcA  = 32'd1234;
    srcB  = 32'd5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      if (lat == 5) begin
        start = 1'b1;
        op    = 2'b10;
        srcA  = 32'hDEAD_BEEF;
        srcB  = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    nChecks++;
    if ({hi, lo} !== exp || lat !== 33) begin
      nFails++;
      $display("FAIL ignore_start got %h lat %0d want %h lat 33",
               {hi, lo}, lat, exp);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic b0, both;
    logic [63:0] exp;
    doOp(2'b00, 32'h0001_2345, 32'hFFFF_8001, lat, b0, both);
    exp = refModel(32, 2'b11, 32'hCAFE_F00D, 32'd1000);
    start = 1'b1;
    op    = 2'b11;
    srcA  = 32'hCAFE_F00D;
    srcB  = 32'd1000;
    @(posedge clk);
    #1;
    start = 1'b0;
    nChecks++;
    if (busy !== 1'b1) begin
      nFails++;
      $display("FAIL b2b_accept got busy %b want 1", busy);
    end
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      @(posedge clk);
      #1;
      lat++;
    end
    nChecks++;
    if ({hi, lo} !== exp || lat !== 33) begin
      nFails++;
      $display("FAIL b2b_result got %h lat %0d want %h lat 33",
               {hi, lo}, lat, exp);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic b0, both;
    logic sawDone;
    logic [63:0] exp;
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    srcA  = 32'd99;
    srcB  = 32'd77;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    nChecks++;
    if (busy !== 1'b0 || {hi, lo} !== 64'd0 || done !== 1'b0) begin
      nFails++;
      $display("FAIL reset_mid got busy=%b hilo=%h done=%b want 0 0 0",
               busy, {hi, lo}, done);
    end
    #2;
    reset   = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) sawDone = 1'b1;
    end
    nChecks++;
    if (sawDone !== 1'b0) begin
      nFails++;
      $display("FAIL reset_abort got activity %b want 0", sawDone);
    end
    exp = refModel(32, 2'b10, 32'hFFFF_FF00, 32'd7);
    doOp(2'b10, 32'hFFFF_FF00, 32'd7, lat, b0, both);
    nChecks++;
    if ({hi, lo} !== exp || lat !== 33) begin
      nFails++;
      $display("FAIL reset_recover got %h lat %0d want %h lat 33",
               {hi, lo}, lat, exp);
    end
  endtask

  task automatic test_random();
    int lat;
    logic b0, both;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    logic        expDz;
    logic [31:0] special [4];
    special[0] = 32'd0;
    special[1] = 32'd1;
    special[2] = 32'hFFFF_FFFF;
    special[3] = 32'h8000_0000;
    exp = refModel(32, 2'b01, 32'd0, 32'd0);
    doOp(2'b01, 32'd0, 32'd0, lat, b0, both);
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(3) == 0) a = special[$urandom_range(3)];
      if ($urandom_range(3) == 0) b = special[$urandom_range(3)];
      expDz = o[1] && (b == 32'd0);
      if (!expDz) exp = refModel(32, o, a, b);
      doOp(o, a, b, lat, b0, both);
      nChecks++;
      if ({hi, lo} !== exp || divZero !== expDz || both !== 1'b0 ||
          lat !== (expDz ? 0 : 33)) begin
        nFails++;
        $display("FAIL rand%0d op%0d a=%h b=%h got %h dz%b lat%0d want %h dz%b",
                 i, o, a, b, {hi, lo}, divZero, lat, exp, expDz);
      end
    end
  endtask

  task automatic test_width8();
    int lat;
    logic [1:0]  o;
    logic [7:0]  a, b;
    logic [63:0] exp;
    doOp8(2'b00, 8'h80, 8'h80, lat);
    nChecks++;
    if ({hi8, lo8} !== 16'h4000 || lat !== 9) begin
      nFails++;
      $display("FAIL w8_mult got %h lat %0d want 4000 lat 9",
               {hi8, lo8}, lat);
    end
    doOp8(2'b10, 8'h81, 8'h03, lat);
    nChecks++;
    if ({hi8, lo8} !== 16'hFFD6) begin
      nFails++;
      $display("FAIL w8_div got %h want FFD6", {hi8, lo8});
    end
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      if (b == 8'd0) b = 8'd1;
      exp = refModel(8, o, {24'd0, a}, {24'd0, b});
      doOp8(o, a, b, lat);
      nChecks++;
      if ({hi8, lo8} !== {exp[39:32], exp[7:0]} || lat !== 9) begin
        nFails++;
        $display("FAIL w8_rand%0d op%0d a=%h b=%h got %h lat%0d want %h",
                 i, o, a, b, {hi8, lo8}, lat, {exp[39:32], exp[7:0]});
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    start8 = 1'b0;
    op     = 2'b00;
    op8    = 2'b00;
    srcA   = '0;
    srcB   = '0;
    srcA8  = '0;
    srcB8  = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
